// File: rtl/mips32_mem_dump.sv
// Read-back engine for the pipe_MIPS32 data memory: once the core halts, it walks a
// word range through a synchronous read port and streams (address, data) beats out.
module mips32_mem_dump #(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk1,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   count,
   input  logic              halted,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_addr,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              busy,
   output logic              done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_HALT,
      S_READ,
      S_CAPT,
      S_HOLD,
      S_FIN
   } state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_cur_addr;
   logic [ADDR_W:0]   r_remaining;
   logic [ADDR_W-1:0] w_next_addr;

   // Natural overflow gives the modulo-2^ADDR_W address wrap.
   assign w_next_addr = r_cur_addr + ADDR_W'(1);

   always_ff @(posedge clk1) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_cur_addr  <= '0;
         r_remaining <= '0;
         mem_rd_en   <= 1'b0;
         mem_addr    <= '0;
         out_valid   <= 1'b0;
         out_addr    <= '0;
         out_data    <= '0;
         out_last    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  busy <= 1'b1;
                  if (count == '0) begin
                     done    <= 1'b1;
                     r_state <= S_FIN;
                  end else begin
                     r_cur_addr  <= base_addr;
                     r_remaining <= count;
                     r_state     <= S_WAIT_HALT;
                  end
               end
            end
            S_WAIT_HALT: begin
               if (halted) begin
                  mem_rd_en <= 1'b1;
                  mem_addr  <= r_cur_addr;
                  r_state   <= S_READ;
               end
            end
            S_READ: begin
               mem_rd_en <= 1'b0;
               r_state   <= S_CAPT;
            end
            S_CAPT: begin
               // Read data is valid this cycle; capture it so the beat is fully registered.
               out_data  <= mem_rd_data;
               out_addr  <= r_cur_addr;
               out_last  <= (r_remaining == (ADDR_W+1)'(1));
               out_valid <= 1'b1;
               r_state   <= S_HOLD;
            end
            S_HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  if (out_last) begin
                     done    <= 1'b1;
                     r_state <= S_FIN;
                  end else begin
                     r_remaining <= r_remaining - (ADDR_W+1)'(1);
                     r_cur_addr  <= w_next_addr;
                     mem_rd_en   <= 1'b1;
                     mem_addr    <= w_next_addr;
                     r_state     <= S_READ;
                  end
               end
            end
            S_FIN: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state   <= S_IDLE;
               mem_rd_en <= 1'b0;
               out_valid <= 1'b0;
               out_last  <= 1'b0;
               busy      <= 1'b0;
               done      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mips32_mem_dump.sv
// Directed bench for mips32_mem_dump: a behavioural synchronous memory feeds the DUT
// and a posedge monitor records beats, read strobes and done pulses.
module tb_mips32_mem_dump;
   localparam int unsigned AW = 10;
   localparam int unsigned DW = 32;

   logic          clk1 = 1'b0;
   logic          rst_n;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [AW:0]   count;
   logic          halted;
   logic          mem_rd_en;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_rd_data = '0;
   logic          out_valid;
   logic          out_ready;
   logic [AW-1:0] out_addr;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic          busy;
   logic          done;

   mips32_mem_dump #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk1(clk1), .rst_n(rst_n), .start(start), .base_addr(base_addr), .count(count),
      .halted(halted), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
      .out_last(out_last), .busy(busy), .done(done)
   );

   always #5 clk1 = ~clk1;

   logic [DW-1:0] mem [0:1023];
   always @(posedge clk1) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

   int beats = 0, rd_cnt = 0, done_cnt = 0;
   logic [AW-1:0] b_addr [64];
   logic [DW-1:0] b_data [64];
   logic          b_last [64];

   always @(posedge clk1) begin
      if (rst_n && out_valid && out_ready) begin
         if (beats < 64) begin
            b_addr[beats] <= out_addr;
            b_data[beats] <= out_data;
            b_last[beats] <= out_last;
         end
         beats <= beats + 1;
      end
      if (mem_rd_en) rd_cnt   <= rd_cnt + 1;
      if (done)      done_cnt <= done_cnt + 1;
   end

   int n_checks = 0, n_pass = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   task automatic start_dump(input logic [AW-1:0] b, input logic [AW:0] c);
      start = 1'b1; base_addr = b; count = c;
      @(negedge clk1);
      start = 1'b0;
   endtask

   task automatic wait_valid(input int maxc);
      int k = 0;
      while (!out_valid && k < maxc) begin @(negedge clk1); k++; end
      check("valid_timeout", 32'(out_valid), 1);
   endtask

   task automatic wait_done(input int target, input int maxc);
      int k = 0;
      while (done_cnt < target && k < maxc) begin @(negedge clk1); k++; end
      check("done_timeout", 32'(done_cnt >= target), 1);
   endtask

   task automatic check_beat(input string tag, input int idx, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input logic l);
      check({tag, "_addr"}, 32'(b_addr[idx]), 32'(a));
      check({tag, "_data"}, b_data[idx], d);
      check({tag, "_last"}, 32'(b_last[idx]), 32'(l));
   endtask

   initial begin
      int b0, r0, d0;
      logic [AW-1:0] ca;
      logic [DW-1:0] cd;
      logic          cl;
      for (int i = 0; i < 1024; i++) mem[i] = '0;
      mem[120] = 85; mem[121] = 130; mem[1023] = 7; mem[0] = 9;
      mem[200] = 11; mem[201] = 22; mem[202] = 33; mem[203] = 44;
      rst_n = 1'b0; start = 1'b0; base_addr = '0; count = '0; halted = 1'b1; out_ready = 1'b1;
      repeat (3) @(negedge clk1);
      check("rst_valid", 32'(out_valid), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_rden", 32'(mem_rd_en), 0);
      check("rst_last", 32'(out_last), 0);
      rst_n = 1'b1;
      @(negedge clk1);

      // 1: basic two-word dump
      b0 = beats; r0 = rd_cnt; d0 = done_cnt;
      start_dump(120, 2);
      wait_done(d0 + 1, 100);
      check("t1_busy_after", 32'(busy), 0);
      @(negedge clk1);
      check("t1_done_low", 32'(done), 0);
      check("t1_done_cnt", 32'(done_cnt - d0), 1);
      check("t1_beats", 32'(beats - b0), 2);
      check("t1_reads", 32'(rd_cnt - r0), 2);
      check_beat("t1_b0", b0, 120, 85, 1'b0);
      check_beat("t1_b1", b0 + 1, 121, 130, 1'b1);

      // 2: backpressure on beat 1
      b0 = beats; r0 = rd_cnt; d0 = done_cnt;
      out_ready = 1'b0;
      start_dump(120, 2);
      wait_valid(20);
      ca = out_addr; cd = out_data; cl = out_last;
      check("t2_first_addr", 32'(ca), 120);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk1);
         check("t2_hold_valid", 32'(out_valid), 1);
         check("t2_hold_addr", 32'(out_addr), 32'(ca));
         check("t2_hold_data", out_data, cd);
         check("t2_hold_last", 32'(out_last), 32'(cl));
      end
      out_ready = 1'b1;
      wait_done(d0 + 1, 100);
      @(negedge clk1);
      check("t2_beats", 32'(beats - b0), 2);
      check("t2_reads", 32'(rd_cnt - r0), 2);
      check_beat("t2_b0", b0, 120, 85, 1'b0);
      check_beat("t2_b1", b0 + 1, 121, 130, 1'b1);

      // 3: wait for halt, ignored restart, halted dropping mid-dump
      b0 = beats; r0 = rd_cnt; d0 = done_cnt;
      halted = 1'b0;
      start_dump(121, 1);
      repeat (10) @(negedge clk1);
      check("t3_no_read", 32'(rd_cnt - r0), 0);
      check("t3_busy_wait", 32'(busy), 1);
      check("t3_no_valid", 32'(out_valid), 0);
      start_dump(300, 5);
      halted = 1'b1;
      @(negedge clk1);
      check("t3_rden", 32'(mem_rd_en), 1);
      check("t3_rdaddr", 32'(mem_addr), 121);
      check("t3_valid_c1", 32'(out_valid), 0);
      halted = 1'b0;
      @(negedge clk1);
      check("t3_valid_c2", 32'(out_valid), 0);
      @(negedge clk1);
      check("t3_valid_c3", 32'(out_valid), 1);
      check("t3_addr", 32'(out_addr), 121);
      check("t3_data", out_data, 130);
      check("t3_last", 32'(out_last), 1);
      wait_done(d0 + 1, 100);
      @(negedge clk1);
      check("t3_beats", 32'(beats - b0), 1);
      check("t3_done_cnt", 32'(done_cnt - d0), 1);
      halted = 1'b1;

      // 4: zero-length dump
      b0 = beats; r0 = rd_cnt; d0 = done_cnt;
      start_dump(50, 0);
      check("t4_done_hi", 32'(done), 1);
      check("t4_busy_hi", 32'(busy), 1);
      @(negedge clk1);
      check("t4_done_lo", 32'(done), 0);
      check("t4_busy_lo", 32'(busy), 0);
      repeat (3) @(negedge clk1);
      check("t4_beats", 32'(beats - b0), 0);
      check("t4_reads", 32'(rd_cnt - r0), 0);
      check("t4_done_cnt", 32'(done_cnt - d0), 1);

      // 5: address wrap
      b0 = beats; d0 = done_cnt;
      start_dump(1023, 2);
      wait_done(d0 + 1, 100);
      @(negedge clk1);
      check("t5_beats", 32'(beats - b0), 2);
      check_beat("t5_b0", b0, 1023, 7, 1'b0);
      check_beat("t5_b1", b0 + 1, 0, 9, 1'b1);

      // 6: reset during HOLD, then a clean restart
      b0 = beats; d0 = done_cnt;
      out_ready = 1'b0;
      start_dump(200, 4);
      wait_valid(20);
      check("t6_pre_addr", 32'(out_addr), 200);
      rst_n = 1'b0;
      @(negedge clk1);
      check("t6_valid", 32'(out_valid), 0);
      check("t6_busy", 32'(busy), 0);
      check("t6_done", 32'(done), 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk1);
      check("t6_no_done", 32'(done_cnt - d0), 0);
      check("t6_no_beat", 32'(beats - b0), 0);
      out_ready = 1'b1;
      start_dump(200, 4);
      wait_done(d0 + 1, 200);
      @(negedge clk1);
      check("t6_beats", 32'(beats - b0), 4);
      check_beat("t6_b0", b0, 200, 11, 1'b0);
      check_beat("t6_b1", b0 + 1, 201, 22, 1'b0);
      check_beat("t6_b2", b0 + 2, 202, 33, 1'b0);
      check_beat("t6_b3", b0 + 3, 203, 44, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got 1 expected 0");
      $fatal(1, "timeout");
   end
endmodule
